// File: rtl/synth_audio_pkg.sv
// rtl/synth_audio_pkg.sv - shared defaults and helpers for the synth audio output path

package synth_audio_pkg;

    localparam int I2S_SLOT_DEFAULT     = 16;
    localparam int SAMPLE_WIDTH_DEFAULT = 12;

    // Frame bit counter for the default slot width (two slots per frame).
    typedef logic [$clog2(2*I2S_SLOT_DEFAULT)-1:0] frame_bit_t;

    function automatic int frame_bits(input int slot_width);
        return 2 * slot_width;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - BCLK/LRCLK generator with fall-event, slot-first and frame-start strobes

module i2s_clkgen
    import synth_audio_pkg::*;
#(
    parameter int SLOT_WIDTH = I2S_SLOT_DEFAULT,
    parameter int BCLK_DIV   = 8
) (
    input  logic main_clk,
    input  logic reset_n,
    output logic bclk,
    output logic lrclk,
    output logic fall,
    output logic slot_first,
    output logic frame_start
);

    localparam int FRAME_BITS = frame_bits(SLOT_WIDTH);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_nxt;
    logic             div_tc;
    logic             frame_end;

    assign div_tc    = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign fall      = div_tc && bclk;
    assign frame_end = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign bit_nxt   = frame_end ? '0 : bit_cnt + 1'b1;

    assign frame_start = fall && frame_end;
    // Fall that drives the MSB of a slot: one bclk after the lrclk edge.
    assign slot_first  = fall && ((bit_cnt == '0) || (bit_cnt == BIT_W'(SLOT_WIDTH)));

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= BIT_W'(FRAME_BITS - 1);
            lrclk   <= 1'b1;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrclk   <= (bit_nxt >= BIT_W'(SLOT_WIDTH));
            end
        end
    end

endmodule

// File: rtl/i2s_sample_tx.sv
// rtl/i2s_sample_tx.sv - mono sample to Philips I2S master transmitter with one-entry buffer
// Optional I2S_TX_UNSIGNED_IN_EN: treat input as offset-binary and flip its MSB on capture.

module i2s_sample_tx
    import synth_audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
    parameter int SLOT_WIDTH   = I2S_SLOT_DEFAULT,
    parameter int BCLK_DIV     = 8
) (
    input  logic                    main_clk,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underrun
);

    logic                    fall;
    logic                    slot_first;
    logic                    frame_start;
    logic                    buffer_full;
    logic [SAMPLE_WIDTH-1:0] hold_data;
    logic [SAMPLE_WIDTH-1:0] last_sample;
    logic [SAMPLE_WIDTH-1:0] captured;
    logic [SLOT_WIDTH-1:0]   slot_word;
    logic [SLOT_WIDTH-1:0]   shift_reg;

    i2s_clkgen #(
        .SLOT_WIDTH (SLOT_WIDTH),
        .BCLK_DIV   (BCLK_DIV)
    ) u_clkgen (
        .main_clk    (main_clk),
        .reset_n     (reset_n),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .fall        (fall),
        .slot_first  (slot_first),
        .frame_start (frame_start)
    );

`ifdef I2S_TX_UNSIGNED_IN_EN
    assign captured = sample_data ^ (SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1));
`else
    assign captured = sample_data;
`endif

    assign slot_word    = SLOT_WIDTH'(last_sample) << (SLOT_WIDTH - SAMPLE_WIDTH);
    assign sample_ready = ~buffer_full;

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer_full <= 1'b0;
            hold_data   <= '0;
            last_sample <= '0;
            shift_reg   <= '0;
            sdata       <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            underrun <= frame_start && !buffer_full;

            // No bypass: a buffer drained at frame start reopens one cycle later.
            if (frame_start && buffer_full) begin
                last_sample <= hold_data;
                buffer_full <= 1'b0;
            end else if (sample_valid && !buffer_full) begin
                hold_data   <= captured;
                buffer_full <= 1'b1;
            end

            // last_sample is still the old word here, so the right-slot LSB at frame start is intact.
            if (slot_first) begin
                sdata     <= slot_word[SLOT_WIDTH-1];
                shift_reg <= slot_word << 1;
            end else if (fall) begin
                sdata     <= shift_reg[SLOT_WIDTH-1];
                shift_reg <= shift_reg << 1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb/tb_i2s_sample_tx.sv - directed vector bench for i2s_sample_tx (BCLK_DIV=2, 16-bit slots)

module tb_i2s_sample_tx;

    logic        main_clk;
    logic        reset_n;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fs_mark = -1;

`ifdef I2S_TX_UNSIGNED_IN_EN
    localparam logic [15:0] W_A5C = 16'h25C0;
    localparam logic [15:0] W_111 = 16'h9110;
    localparam logic [15:0] W_222 = 16'hA220;
`else
    localparam logic [15:0] W_A5C = 16'hA5C0;
    localparam logic [15:0] W_111 = 16'h1110;
    localparam logic [15:0] W_222 = 16'h2220;
`endif

    typedef struct {
        logic [11:0] sample;
        logic [15:0] word;
    } vec_t;

    vec_t vecs[5];

    i2s_sample_tx #(
        .SAMPLE_WIDTH (12),
        .SLOT_WIDTH   (16),
        .BCLK_DIV     (2)
    ) dut (
        .main_clk     (main_clk),
        .reset_n      (reset_n),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;
    always @(posedge main_clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [11:0] d, output int acc_cyc);
        sample_data  = d;
        sample_valid = 1'b1;
        acc_cyc      = -1;
        for (int i = 0; i < 400; i++) begin
            if (sample_ready) begin
                tick();
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        sample_valid = 1'b0;
        if (acc_cyc < 0) check("send timeout", 0, 1);
    endtask

    task automatic wait_frame(output bit ok);
        logic prev;
        ok = 1'b0;
        if (cyc == fs_mark) begin
            ok = 1'b1;
            return;
        end
        for (int i = 0; i < 400; i++) begin
            prev = lrclk;
            tick();
            if (prev && !lrclk) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Captures one full frame; ends on the next frame-start tick and marks it.
    task automatic frame(input logic [15:0] w, input logic eu, input string nm);
        bit          ok;
        logic [31:0] got;
        int          lr_err;
        int          und_cnt;
        wait_frame(ok);
        if (!ok) begin
            check({nm, " frame start timeout"}, 0, 1);
            return;
        end
        check({nm, " underrun at start"}, 32'(underrun), 32'(eu));
        got = '0;
        lr_err = 0;
        und_cnt = 0;
        for (int k = 1; k <= 32; k++) begin
            for (int j = 1; j <= 4; j++) begin
                tick();
                if (underrun && !(k == 32 && j == 4)) und_cnt++;
            end
            got = {got[30:0], sdata};
            if (lrclk !== ((k >= 16) && (k < 32))) lr_err++;
        end
        fs_mark = cyc;
        check({nm, " slot data"}, got, {w, w});
        check({nm, " lrclk pattern errors"}, 32'(lr_err), 0);
        check({nm, " extra underrun cycles"}, 32'(und_cnt), 0);
    endtask

    initial begin
        int          acc1;
        int          acc2;
        int          acc;
        int          fs3;
        int          fs4;
        int          n;
        logic [15:0] prev_w;

        vecs[0] = '{12'h800, 16'h8000};
        vecs[1] = '{12'h000, 16'h0000};
        vecs[2] = '{12'hFFF, 16'hFFF0};
        vecs[3] = '{12'h7FF, 16'h7FF0};
        vecs[4] = '{12'h001, 16'h0010};
`ifdef I2S_TX_UNSIGNED_IN_EN
        vecs[0].word = 16'h0000;
        vecs[1].word = 16'h8000;
        vecs[2].word = 16'h7FF0;
        vecs[3].word = 16'hFFF0;
        vecs[4].word = 16'h8010;
`endif

        reset_n      = 1'b0;
        sample_data  = '0;
        sample_valid = 1'b0;
        repeat (3) tick();
        check("reset outputs {bclk,lrclk,sdata,ready,underrun}",
              {27'd0, bclk, lrclk, sdata, sample_ready, underrun}, 32'b01010);

        sample_data  = 12'hA5C;
        sample_valid = 1'b1;
        reset_n      = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("ready after first accept", 32'(sample_ready), 0);
        n = 1;
        while (lrclk && n < 20) begin
            tick();
            n++;
        end
        check("cycles to first fall", 32'(n), 4);
        fs_mark = cyc;
        frame(W_A5C, 1'b0, "frame1");
        frame(W_A5C, 1'b1, "frame2 repeat");

        fs3 = cyc;
        fork
            begin
                send(12'h111, acc1);
                send(12'h222, acc2);
            end
            begin
                frame(W_A5C, 1'b1, "frame3");
                fs4 = fs_mark;
                frame(W_111, 1'b0, "frame4 111");
                frame(W_222, 1'b0, "frame5 222");
            end
        join
        check("111 accept cycle", 32'(acc1 - fs3), 1);
        check("222 accept after frame start", 32'(acc2 - fs4), 1);

        prev_w = W_222;
        for (int i = 0; i < 5; i++) begin
            fork
                send(vecs[i].sample, acc);
                frame(prev_w, 1'b1, $sformatf("vec%0d idle", i));
            join
            frame(vecs[i].word, 1'b0, $sformatf("vec%0d data", i));
            prev_w = vecs[i].word;
        end

        send(12'h333, acc);
        repeat (20) tick();
        check("mid-slot {lrclk,ready}", {30'd0, lrclk, sample_ready}, 0);
        reset_n = 1'b0;
        #1;
        check("async reset outputs", {27'd0, bclk, lrclk, sdata, sample_ready, underrun}, 32'b01010);
        repeat (2) tick();
        reset_n = 1'b1;
        n = 0;
        while (lrclk && n < 20) begin
            tick();
            n++;
        end
        check("cycles to first fall after reset", 32'(n), 4);
        fs_mark = cyc;
        frame(16'h0000, 1'b1, "post-reset frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
